// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with one-cycle result pulses.
// Optional feature macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each bit centre.
module uart_rx #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             RX_IN,
  input  logic [5:0]       Prescale,
  input  logic             Parity_EN,
  input  logic             Parity_type,
  output logic [width-1:0] Data_out,
  output logic             Data_valid,
  output logic             Parity_error,
  output logic             Stop_error
);
  localparam int BCW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           r_state, w_next;
  logic [5:0]       r_prescale, r_edge_cnt;
  logic [BCW-1:0]   r_bit_cnt;
  logic             r_par_en, r_par_type, r_par_err, r_sample;
  logic [width-1:0] r_shift;
  logic [width:0]   w_shift_in;
  logic [5:0]       w_half, w_prescale_dec;
  logic             w_last, w_sample_en, w_sample;

  assign w_prescale_dec = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
  assign w_half         = {1'b0, r_prescale[5:1]};
  assign w_last         = (r_edge_cnt == r_prescale - 6'd1);
  assign w_shift_in     = {r_sample, r_shift};

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_vote;

  // The vote completes one edge after the centre, still well before the bit's last edge.
  assign w_sample_en = (r_edge_cnt == w_half + 6'd1);
  assign w_sample    = (r_vote[0] & r_vote[1]) | (r_vote[0] & RX_IN) | (r_vote[1] & RX_IN);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_vote <= 2'b11;
    end else begin
      if (r_edge_cnt == w_half - 6'd1) r_vote[0] <= RX_IN;
      if (r_edge_cnt == w_half)        r_vote[1] <= RX_IN;
    end
  end
`else
  assign w_sample_en = (r_edge_cnt == w_half);
  assign w_sample    = RX_IN;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: non-blocking (<=) in clocked blocks so every register sees pre-edge values.
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:    if (!RX_IN) w_next = START;
      START:   if (w_last) w_next = r_sample ? IDLE : DATA;
      DATA:    if (w_last && r_bit_cnt == LAST_BIT) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_last) w_next = STOP;
      STOP:    if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_prescale   <= 6'd8;
      r_par_en     <= 1'b0;
      r_par_type   <= 1'b0;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_sample     <= 1'b1;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      Data_out     <= '0;
      Data_valid   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
    end else begin
      Data_valid   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
      if (w_sample_en) r_sample <= w_sample;

      if (r_state == IDLE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
        r_par_err  <= 1'b0;
        // Frame settings freeze here; later input changes wait for the next frame.
        if (!RX_IN) begin
          r_prescale <= w_prescale_dec;
          r_par_en   <= Parity_EN;
          r_par_type <= Parity_type;
        end
      end else begin
        r_edge_cnt <= w_last ? 6'd0 : r_edge_cnt + 6'd1;
      end

      if (w_last) begin
        case (r_state)
          DATA: begin
            r_shift   <= w_shift_in[width:1];
            r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
          end
          PARITY: r_par_err <= (r_sample != (^r_shift ^ r_par_type));
          STOP: begin
            if (!r_sample) begin
              Stop_error <= 1'b1;
            end else if (r_par_err) begin
              Parity_error <= 1'b1;
            end else begin
              Data_valid <= 1'b1;
              Data_out   <= r_shift;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
